pong_engine: RTL and testbench

//  Frame-rate game core for two-player pong: paddle motion, 2-D ball motion, wall/paddle bounces,

---
 rtl/pong_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: frame-rate game core for two-player pong.
//   Moves both paddles and the ball once per frame_tick, bounces the ball off
//   the top/bottom walls and the paddles, scores misses, and sequences
//   SERVE -> PLAY -> PAUSE -> (SERVE | OVER). All outputs are registered and
//   change one clock after the frame_tick cycle that caused them.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_frame_tick                one-cycle pulse per frame
//   i_p1_up/i_p1_dn/i_p1_srv    left player controls (level)
//   i_p2_up/i_p2_dn/i_p2_srv    right player controls (level)
//   o_p1_y, o_p2_y              paddle top edges
//   o_ball_x, o_ball_y          ball top-left corner
//   o_score1, o_score2          scores
//   o_state                     0 SERVE, 1 PLAY, 2 PAUSE, 3 OVER
//   o_point_evt                 one-cycle pulse when a point is scored
module pong_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PAD_H        = 50,
    parameter int PAD_W        = 8,
    parameter int BALL_SZ      = 8,
    parameter int P1_X         = 40,
    parameter int P2_X         = 600,
    parameter int P_SPD        = 8,
    parameter int BX_SPD       = 8,
    parameter int BY_SPD       = 4,
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_tick,
    input  logic       i_p1_up,
    input  logic       i_p1_dn,
    input  logic       i_p1_srv,
    input  logic       i_p2_up,
    input  logic       i_p2_dn,
    input  logic       i_p2_srv,
    output logic [8:0] o_p1_y,
    output logic [8:0] o_p2_y,
    output logic [9:0] o_ball_x,
    output logic [8:0] o_ball_y,
    output logic [3:0] o_score1,
    output logic [3:0] o_score2,
    output logic [1:0] o_state,
    output logic       o_point_evt
);
    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int PCW = $clog2(PAUSE_FRAMES + 1);

    // All position arithmetic is done in 11-bit signed so that steps past
    // either screen edge go negative/over-range and are clamped, never wrapped.
    localparam logic signed [10:0] PAD_MAX   = 11'(SCREEN_H - PAD_H);
    localparam logic signed [10:0] BALL_YMAX = 11'(SCREEN_H - BALL_SZ);
    localparam logic signed [10:0] BALL_XMAX = 11'(SCREEN_W - BALL_SZ);
    localparam logic signed [10:0] P_STEP    = 11'(P_SPD);
    localparam logic signed [10:0] BX_STEP   = 11'(BX_SPD);
    localparam logic signed [10:0] BY_STEP   = 11'(BY_SPD);
    localparam logic signed [10:0] L_X0      = 11'(P1_X);
    localparam logic signed [10:0] L_X1      = 11'(P1_X + PAD_W);
    localparam logic signed [10:0] R_X0      = 11'(P2_X);
    localparam logic signed [10:0] R_X1      = 11'(P2_X + PAD_W);
    localparam logic signed [10:0] BALL      = 11'(BALL_SZ);
    localparam logic signed [10:0] PADH      = 11'(PAD_H);
    localparam logic signed [10:0] HALF_B    = 11'(BALL_SZ / 2);
    localparam logic signed [10:0] HALF_P    = 11'(PAD_H / 2);
    localparam logic signed [10:0] ZERO      = 11'sd0;

    localparam logic [8:0] PAD_INIT   = 9'((SCREEN_H - PAD_H) / 2);
    localparam logic [8:0] SERVE_OFS  = 9'(PAD_H / 2 - BALL_SZ / 2);
    localparam logic [9:0] SERVE_X_L  = 10'(P1_X + PAD_W);
    localparam logic [9:0] SERVE_X_R  = 10'(P2_X - BALL_SZ);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [PCW-1:0] PAUSE_LAST = PCW'(PAUSE_FRAMES - 1);

    logic [8:0]     r_p1_y, r_p2_y, r_ball_y;
    logic [9:0]     r_ball_x;
    logic [3:0]     r_score1, r_score2;
    logic [1:0]     r_state;
    logic           r_point_evt, r_srv_left, r_dx_pos, r_dy_pos;
    logic [PCW-1:0] r_pause_cnt;

    logic [8:0]     w_p1_y_next, w_p2_y_next, w_ball_y_next;
    logic [9:0]     w_ball_x_next;
    logic [3:0]     w_score1_next, w_score2_next;
    logic [1:0]     w_state_next;
    logic           w_point_evt_next, w_srv_left_next, w_dx_pos_next, w_dy_pos_next;
    logic [PCW-1:0] w_pause_cnt_next;

    logic signed [10:0] w_nx, w_ny, w_ny_w, w_p1_top, w_p2_top;
    logic               w_dy_wall, w_hit_l, w_hit_r, w_ctr_above_l, w_ctr_above_r;

    function automatic logic [8:0] step_pad(input logic [8:0] y, input logic up, input logic dn);
        logic signed [10:0] t;
        t = $signed({2'b00, y});
        if (up && !dn)
            t = t - P_STEP;
        else if (dn && !up)
            t = t + P_STEP;
        if (t < ZERO)
            t = ZERO;
        else if (t > PAD_MAX)
            t = PAD_MAX;
        return t[8:0];
    endfunction

    // Ball physics for a PLAY tick; hit tests use the paddles as they were
    // before this tick's paddle movement.
    always_comb begin
        w_nx      = $signed({1'b0, r_ball_x}) + (r_dx_pos ? BX_STEP : -BX_STEP);
        w_ny      = $signed({2'b00, r_ball_y}) + (r_dy_pos ? BY_STEP : -BY_STEP);
        w_ny_w    = w_ny;
        w_dy_wall = r_dy_pos;
        if (w_ny < ZERO) begin
            w_ny_w    = ZERO;
            w_dy_wall = 1'b1;
        end else if (w_ny > BALL_YMAX) begin
            w_ny_w    = BALL_YMAX;
            w_dy_wall = 1'b0;
        end
        w_p1_top      = $signed({2'b00, r_p1_y});
        w_p2_top      = $signed({2'b00, r_p2_y});
        w_hit_l       = !r_dx_pos && (w_nx < L_X1) && (w_nx + BALL > L_X0)
                        && (w_ny_w < w_p1_top + PADH) && (w_ny_w + BALL > w_p1_top);
        w_hit_r       = r_dx_pos && (w_nx < R_X1) && (w_nx + BALL > R_X0)
                        && (w_ny_w < w_p2_top + PADH) && (w_ny_w + BALL > w_p2_top);
        w_ctr_above_l = (w_ny_w + HALF_B) < (w_p1_top + HALF_P);
        w_ctr_above_r = (w_ny_w + HALF_B) < (w_p2_top + HALF_P);
    end

    always_comb begin
        w_p1_y_next      = r_p1_y;
        w_p2_y_next      = r_p2_y;
        w_ball_x_next    = r_ball_x;
        w_ball_y_next    = r_ball_y;
        w_score1_next    = r_score1;
        w_score2_next    = r_score2;
        w_state_next     = r_state;
        w_point_evt_next = 1'b0;
        w_srv_left_next  = r_srv_left;
        w_dx_pos_next    = r_dx_pos;
        w_dy_pos_next    = r_dy_pos;
        w_pause_cnt_next = r_pause_cnt;

        if (i_frame_tick) begin
            if (r_state != ST_OVER) begin
                w_p1_y_next = step_pad(r_p1_y, i_p1_up, i_p1_dn);
                w_p2_y_next = step_pad(r_p2_y, i_p2_up, i_p2_dn);
            end

            case (r_state)
                ST_PLAY: begin
                    w_ball_y_next = w_ny_w[8:0];
                    w_dy_pos_next = w_dy_wall;
                    if (w_hit_l) begin
                        w_ball_x_next = SERVE_X_L;
                        w_dx_pos_next = 1'b1;
                        w_dy_pos_next = !w_ctr_above_l;
                    end else if (w_hit_r) begin
                        w_ball_x_next = SERVE_X_R;
                        w_dx_pos_next = 1'b0;
                        w_dy_pos_next = !w_ctr_above_r;
                    end else if (w_nx <= ZERO) begin
                        w_ball_x_next    = 10'd0;
                        w_score2_next    = r_score2 + 4'd1;
                        w_srv_left_next  = 1'b1;
                        w_point_evt_next = 1'b1;
                        w_state_next     = ST_PAUSE;
                        w_pause_cnt_next = '0;
                    end else if (w_nx >= BALL_XMAX) begin
                        w_ball_x_next    = BALL_XMAX[9:0];
                        w_score1_next    = r_score1 + 4'd1;
                        w_srv_left_next  = 1'b0;
                        w_point_evt_next = 1'b1;
                        w_state_next     = ST_PAUSE;
                        w_pause_cnt_next = '0;
                    end else begin
                        w_ball_x_next = w_nx[9:0];
                    end
                end
                ST_PAUSE: begin
                    if (r_pause_cnt == PAUSE_LAST) begin
                        // Scores cannot change while paused, so testing them
                        // here is the same as testing them on entry.
                        if (r_score1 == WIN || r_score2 == WIN)
                            w_state_next = ST_OVER;
                        else
                            w_state_next = ST_SERVE;
                    end else begin
                        w_pause_cnt_next = r_pause_cnt + PCW'(1);
                    end
                end
                ST_OVER: begin
                    if (i_p1_srv && i_p2_srv) begin
                        w_score1_next   = 4'd0;
                        w_score2_next   = 4'd0;
                        w_srv_left_next = 1'b0;
                        w_state_next    = ST_SERVE;
                    end
                end
                default: begin
                    if (r_srv_left ? i_p1_srv : i_p2_srv)
                        w_state_next = ST_PLAY;
                end
            endcase

            // Park the ball on the server's paddle on every SERVE tick and on
            // the tick that enters SERVE, so it is in place as soon as SERVE shows.
            if (r_state == ST_SERVE || w_state_next == ST_SERVE) begin
                w_ball_x_next = w_srv_left_next ? SERVE_X_L : SERVE_X_R;
                w_ball_y_next = (w_srv_left_next ? w_p1_y_next : w_p2_y_next) + SERVE_OFS;
                w_dx_pos_next = w_srv_left_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_y      <= PAD_INIT;
            r_p2_y      <= PAD_INIT;
            r_ball_x    <= SERVE_X_R;
            r_ball_y    <= PAD_INIT + SERVE_OFS;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_state     <= ST_SERVE;
            r_point_evt <= 1'b0;
            r_srv_left  <= 1'b0;
            r_dx_pos    <= 1'b0;
            r_dy_pos    <= 1'b1;
            r_pause_cnt <= '0;
        end else begin
            r_p1_y      <= w_p1_y_next;
            r_p2_y      <= w_p2_y_next;
            r_ball_x    <= w_ball_x_next;
            r_ball_y    <= w_ball_y_next;
            r_score1    <= w_score1_next;
            r_score2    <= w_score2_next;
            r_state     <= w_state_next;
            r_point_evt <= w_point_evt_next;
            r_srv_left  <= w_srv_left_next;
            r_dx_pos    <= w_dx_pos_next;
            r_dy_pos    <= w_dy_pos_next;
            r_pause_cnt <= w_pause_cnt_next;
        end
    end

    assign o_p1_y      = r_p1_y;
    assign o_p2_y      = r_p2_y;
    assign o_ball_x    = r_ball_x;
    assign o_ball_y    = r_ball_y;
    assign o_score1    = r_score1;
    assign o_score2    = r_score2;
    assign o_state     = r_state;
    assign o_point_evt = r_point_evt;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed bench for pong_engine. Drives frame ticks with
// player inputs and compares outputs against hand-derived trajectories.
module tb_pong_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, p1u, p1d, p1s, p2u, p2d, p2s;
    logic [8:0] p1y, p2y, by;
    logic [9:0] bx;
    logic [3:0] s1, s2;
    logic [1:0] st;
    logic       pe;

    int n_checks = 0;
    int n_errors = 0;

    pong_engine dut (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(tick),
        .i_p1_up(p1u), .i_p1_dn(p1d), .i_p1_srv(p1s),
        .i_p2_up(p2u), .i_p2_dn(p2d), .i_p2_srv(p2s),
        .o_p1_y(p1y), .o_p2_y(p2y), .o_ball_x(bx), .o_ball_y(by),
        .o_score1(s1), .o_score2(s2), .o_state(st), .o_point_evt(pe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick with the given inputs; returns at the falling edge after
    // the updating clock edge, where the new outputs are stable.
    task automatic frame(input logic a1u, a1d, a1s, a2u, a2d, a2s);
        @(negedge clk);
        {p1u, p1d, p1s, p2u, p2d, p2s} = {a1u, a1d, a1s, a2u, a2d, a2s};
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        {p1u, p1d, p1s, p2u, p2d, p2s} = 6'b0;
    endtask

    // Right serves from (592,236); left paddle parked to return the ball;
    // left scores at the right edge. Rally A starts with dy=+1 (bottom wall
    // bounce, return off p1_y=430), rally B with dy=-1 (top wall, p1_y=0).
    task automatic left_point(input bit rally_a, input int pt);
        int ex, ey;
        frame(0, 0, 0, 0, 0, 1);
        check("serve_state", st, 1);
        check("serve_x", bx, 592);
        for (int k = 1; k <= 69; k++) begin
            frame(0, 0, 0, 0, 0, 0);
            ex = (k == 69) ? 48 : 592 - 8 * k;
            if (rally_a) ey = (k <= 59) ? 236 + 4 * k : 472 - 4 * (k - 60);
            else         ey = (k <= 59) ? 236 - 4 * k : 4 * (k - 60);
            check("fly_left_x", bx, ex);
            check("fly_left_y", by, ey);
            check("fly_left_evt", pe, 0);
        end
        check("after_hit_state", st, 1);
        for (int j = 1; j <= 73; j++) begin
            frame(0, 0, 0, 0, 0, 0);
            ey = rally_a ? 436 - 4 * j : 36 + 4 * j;
            check("fly_right_x", bx, 48 + 8 * j);
            check("fly_right_y", by, ey);
            if (j < 73) begin
                check("fly_right_state", st, 1);
            end else begin
                check("lpoint_evt", pe, 1);
                check("lpoint_score1", s1, pt);
                check("lpoint_score2", s2, 0);
                check("lpoint_state", st, 2);
            end
        end
        @(negedge clk);
        check("lpoint_evt_pulse", pe, 0);
        for (int p = 1; p <= 60; p++) begin
            frame(rally_a, !rally_a, 0, 0, 0, 0);
            if (p < 60) check("pause_state", st, 2);
            if (p == 30) check("pause_frozen_x", bx, 632);
        end
        check("pause_p1_y", p1y, rally_a ? 0 : 430);
        if (pt == 9) begin
            check("over_state", st, 3);
        end else begin
            check("post_pause_state", st, 0);
            check("post_pause_x", bx, 592);
            check("post_pause_y", by, 236);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ey;
        rst_n = 1'b0;
        tick  = 1'b0;
        {p1u, p1d, p1s, p2u, p2d, p2s} = 6'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values, idle ticks, hold between ticks
        repeat (3) frame(0, 0, 0, 0, 0, 0);
        check("rst_p1_y", p1y, 215);
        check("rst_p2_y", p2y, 215);
        check("rst_ball_x", bx, 592);
        check("rst_ball_y", by, 236);
        check("rst_state", st, 0);
        check("rst_score1", s1, 0);
        check("rst_score2", s2, 0);
        check("rst_evt", pe, 0);

        // Left paddle up with top clamp, then up+dn hold
        for (int k = 1; k <= 30; k++) begin
            frame(1, 0, 0, 0, 0, 0);
            check("p1_up", p1y, (215 - 8 * k > 0) ? 215 - 8 * k : 0);
        end
        repeat (2) frame(1, 1, 0, 0, 0, 0);
        check("p1_both", p1y, 0);
        // Left paddle down with bottom clamp
        for (int k = 1; k <= 60; k++) begin
            frame(0, 1, 0, 0, 0, 0);
            check("p1_dn", p1y, (8 * k < 430) ? 8 * k : 430);
        end
        check("serve_ball_x", bx, 592);
        check("serve_ball_y", by, 236);
        // Ball follows the right server's paddle
        frame(0, 0, 0, 0, 1, 0);
        check("p2_dn", p2y, 223);
        check("follow_y_dn", by, 244);
        frame(0, 0, 0, 1, 0, 0);
        check("p2_up", p2y, 215);
        check("follow_y_up", by, 236);
        // Non-server serve is ignored
        frame(0, 0, 1, 0, 0, 0);
        check("p1_srv_ignored", st, 0);

        // Nine points for the left player, alternating rally geometry
        for (int pt = 1; pt <= 9; pt++) left_point(pt % 2 == 1, pt);

        // OVER: everything frozen, single serve ignored, both serve restarts
        check("over_score1", s1, 9);
        frame(0, 1, 0, 1, 0, 0);
        check("over_p1_frozen", p1y, 0);
        check("over_p2_frozen", p2y, 215);
        check("over_bx_frozen", bx, 632);
        check("over_by_frozen", by, 144);
        check("over_state_hold", st, 3);
        frame(0, 0, 1, 0, 0, 0);
        check("over_one_srv", st, 3);
        frame(0, 0, 1, 0, 0, 1);
        check("restart_state", st, 0);
        check("restart_score1", s1, 0);
        check("restart_score2", s2, 0);
        check("restart_bx", bx, 592);
        check("restart_by", by, 236);

        // Left paddle out of the way; right player scores at the left edge
        repeat (60) frame(0, 1, 0, 0, 0, 0);
        check("miss_p1_y", p1y, 430);
        frame(0, 0, 0, 0, 0, 1);
        check("miss_serve_state", st, 1);
        for (int k = 1; k <= 73; k++) begin
            frame(0, 0, 0, 0, 0, 0);
            ey = (k <= 59) ? 236 - 4 * k : 4 * (k - 60);
            check("miss_x", bx, 592 - 8 * k);
            check("miss_y", by, ey);
            check("miss_evt", pe, 0);
        end
        frame(0, 0, 0, 0, 0, 0);
        check("rpoint_x", bx, 0);
        check("rpoint_y", by, 56);
        check("rpoint_evt", pe, 1);
        check("rpoint_score2", s2, 1);
        check("rpoint_score1", s1, 0);
        check("rpoint_state", st, 2);
        @(negedge clk);
        check("rpoint_evt_pulse", pe, 0);
        for (int p = 1; p <= 60; p++) begin
            frame(0, 0, 0, 0, 0, 0);
            if (p < 60) check("rpause_state", st, 2);
        end
        check("lserve_state", st, 0);
        check("lserve_x", bx, 48);
        check("lserve_y", by, 451);
        frame(0, 0, 0, 0, 0, 1);
        check("p2_srv_ignored", st, 0);
        frame(0, 0, 1, 0, 0, 0);
        check("lserve_play", st, 1);
        frame(0, 0, 0, 0, 0, 0);
        check("lplay_x", bx, 56);
        check("lplay_y", by, 455);

        // Asynchronous reset mid-play, ticks ignored while held
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_p1_y", p1y, 215);
        check("arst_ball_x", bx, 592);
        check("arst_ball_y", by, 236);
        check("arst_state", st, 0);
        check("arst_score2", s2, 0);
        frame(1, 0, 0, 0, 0, 0);
        check("arst_tick_ignored", p1y, 215);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 0, 0, 0, 0, 0);
        check("post_rst_state", st, 0);
        check("post_rst_x", bx, 592);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
